// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port IDs, default widths.
package mem_arb_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

endpackage

// File: rtl/mem_arb_grant.sv
// Two-requester grant logic. Round-robin on conflict by default;
// MEM_ARB_DATA_PRIORITY_EN makes the data port win every conflict (no last-grant state).
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic en,
  input  logic i_valid,
  input  logic d_valid,
  output logic gnt_i_c,
  output logic gnt_d_c
);

`ifdef MEM_ARB_DATA_PRIORITY_EN

  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clock, reset_n};

  always_comb begin
    gnt_i_c = 1'b0;
    gnt_d_c = 1'b0;
    if (en) begin
      gnt_d_c = d_valid;
      gnt_i_c = i_valid & ~d_valid;
    end
  end

`else

  port_t last_q;

  // On conflict the port that was not granted last wins.
  always_comb begin
    gnt_i_c = 1'b0;
    gnt_d_c = 1'b0;
    if (en) begin
      if (i_valid && d_valid) begin
        if (last_q == PORT_D) gnt_i_c = 1'b1;
        else                  gnt_d_c = 1'b1;
      end else begin
        gnt_i_c = i_valid;
        gnt_d_c = d_valid;
      end
    end
  end

  // Resets to data so the first conflict goes to instruction fetch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     last_q <= PORT_D;
    else if (gnt_i_c) last_q <= PORT_I;
    else if (gnt_d_c) last_q <= PORT_D;
  end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-port RAM.
// Optional build macro: MEM_ARB_DATA_PRIORITY_EN (data port always wins conflicts).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic                  i_resp_valid,
  output logic [DATA_WIDTH-1:0] i_read_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_wEn,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [DATA_WIDTH-1:0] d_write_data,
  output logic                  d_resp_valid,
  output logic [DATA_WIDTH-1:0] d_read_data,
  output logic                  mem_en,
  output logic                  mem_wEn,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  state_t                state_q, state_d;
  port_t                 port_q;
  logic                  wen_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  accept_en_c;
  logic                  gnt_i_c, gnt_d_c;

  // Reset gates acceptance so ready stays low while reset_n is asserted.
  assign accept_en_c = reset_n & ((state_q == IDLE) | (state_q == RESP));
  assign i_req_ready = gnt_i_c;
  assign d_req_ready = gnt_d_c;

  mem_arb_grant u_grant (
    .clock   (clock),
    .reset_n (reset_n),
    .en      (accept_en_c),
    .i_valid (i_req_valid),
    .d_valid (d_req_valid),
    .gnt_i_c (gnt_i_c),
    .gnt_d_c (gnt_d_c)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Capture the granted request; instruction fetches never carry write data.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      port_q  <= PORT_I;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (gnt_d_c) begin
      port_q  <= PORT_D;
      wen_q   <= d_wEn;
      addr_q  <= d_address;
      wdata_q <= d_write_data;
    end else if (gnt_i_c) begin
      port_q  <= PORT_I;
      wen_q   <= 1'b0;
      addr_q  <= i_address;
      wdata_q <= '0;
    end
  end

  always_comb begin
    state_d        = state_q;
    mem_en         = 1'b0;
    mem_wEn        = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    i_resp_valid   = 1'b0;
    i_read_data    = '0;
    d_resp_valid   = 1'b0;
    d_read_data    = '0;
    case (state_q)
      IDLE: begin
        if (gnt_i_c || gnt_d_c) state_d = ACCESS;
      end
      ACCESS: begin
        state_d        = RESP;
        mem_en         = 1'b1;
        mem_wEn        = wen_q;
        mem_address    = addr_q;
        mem_write_data = wdata_q;
      end
      RESP: begin
        state_d = (gnt_i_c || gnt_d_c) ? ACCESS : IDLE;
        if (port_q == PORT_I) begin
          i_resp_valid = 1'b1;
          i_read_data  = mem_read_data;
        end else begin
          d_resp_valid = 1'b1;
          d_read_data  = wen_q ? '0 : mem_read_data;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
